// File: rtl/scancode_fifo.sv
// PS/2 scancode decoder feeding a DEPTH-entry FIFO of {ext, code} make codes.
// Break sequences are discarded; entries are popped with a one-cycle read latency.
module scancode_fifo #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rd_req,
    output logic [8:0]        rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    typedef enum logic [1:0] {
        NORM   = 2'd0,
        EXT    = 2'd1,
        BRK    = 2'd2,
        EXTBRK = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    state_t              state;
    state_t              state_next;
    logic                push_req;
    logic [8:0]          push_data;
    logic                do_push;
    logic                do_pop;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [ADDR_W:0]     count_next;
    logic [8:0]          mem [DEPTH];

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_next = state;
        push_req   = 1'b0;
        push_data  = {1'b0, rx_data};
        if (rx_valid) begin
            case (state)
                NORM: begin
                    if (rx_data == 8'hE0) begin
                        state_next = EXT;
                    end else if (rx_data == 8'hF0) begin
                        state_next = BRK;
                    end else if (rx_data != 8'h00 && rx_data != 8'hFF) begin
                        push_req = 1'b1;
                    end
                end
                EXT: begin
                    if (rx_data == 8'hF0) begin
                        state_next = EXTBRK;
                    end else if (rx_data != 8'hE0) begin
                        push_req   = 1'b1;
                        push_data  = {1'b1, rx_data};
                        state_next = NORM;
                    end
                end
                default: state_next = NORM;
            endcase
        end
    end

    // A full FIFO still accepts a push when a pop frees a slot in the same edge.
    assign do_pop  = rd_req && !empty;
    assign do_push = push_req && (!full || do_pop);

    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // NOTE: the storage array has no reset; stale entries are unreachable until rewritten.
    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= NORM;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= 9'h000;
        end else begin
            state    <= state_next;
            rd_valid <= do_pop;
            count    <= count_next;
            empty    <= (count_next == '0);
            full     <= (count_next == FULL_COUNT);
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            if (push_req && full && !do_pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_scancode_fifo.sv
// Self-checking bench for scancode_fifo: directed scenarios plus randomized traffic
// compared against a queue-based model of the decode and FIFO rules.
module tb_scancode_fifo;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              clk;
    logic              reset;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rd_req;
    logic [8:0]        rd_data;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              overflow;

    scancode_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rd_req   (rd_req),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pending prefix flags and a queue of stored entries.
    bit         ext_seen;
    bit         brk_seen;
    logic [8:0] q[$];
    logic [8:0] exp_rd_data;
    bit         exp_rd_valid;
    bit         exp_overflow;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_byte(input logic [7:0] b, output bit push, output logic [8:0] d);
        push = 1'b0;
        d    = 9'h000;
        if (brk_seen) begin
            brk_seen = 1'b0;
            ext_seen = 1'b0;
        end else if (b == 8'hF0) begin
            brk_seen = 1'b1;
        end else if (b == 8'hE0) begin
            ext_seen = 1'b1;
        end else if (ext_seen) begin
            push     = 1'b1;
            d        = {1'b1, b};
            ext_seen = 1'b0;
        end else if (b != 8'h00 && b != 8'hFF) begin
            push = 1'b1;
            d    = {1'b0, b};
        end
    endtask

    task automatic step(input bit rst, input bit rv, input logic [7:0] b, input bit rr);
        bit         push;
        bit         pop;
        logic [8:0] d;
        reset    = rst;
        rx_valid = rv;
        rx_data  = b;
        rd_req   = rr;
        if (rst) begin
            ext_seen     = 1'b0;
            brk_seen     = 1'b0;
            q.delete();
            exp_rd_data  = 9'h000;
            exp_rd_valid = 1'b0;
            exp_overflow = 1'b0;
        end else begin
            push = 1'b0;
            d    = 9'h000;
            if (rv) model_byte(b, push, d);
            pop = rr && (q.size() != 0);
            exp_rd_valid = pop;
            if (push && q.size() == DEPTH && !pop) exp_overflow = 1'b1;
            if (pop) exp_rd_data = q.pop_front();
            if (push && q.size() < DEPTH) q.push_back(d);
        end
        @(posedge clk);
        #1;
        check("rd_valid", 32'(rd_valid), 32'(exp_rd_valid));
        check("rd_data",  32'(rd_data),  32'(exp_rd_data));
        check("count",    32'(count),    q.size());
        check("empty",    32'(empty),    32'(q.size() == 0));
        check("full",     32'(full),     32'(q.size() == DEPTH));
        check("overflow", 32'(overflow), 32'(exp_overflow));
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b0, 1'b1, b, 1'b0);
    endtask

    task automatic pop_one();
        step(1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    function automatic logic [7:0] rand_byte();
        int r;
        r = $urandom_range(0, 99);
        if (r < 15) return 8'hE0;
        if (r < 30) return 8'hF0;
        if (r < 34) return 8'h00;
        if (r < 37) return 8'hFF;
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rd_req   = 1'b0;
        @(negedge clk);

        // Reset with simultaneous traffic must ignore that traffic.
        step(1'b1, 1'b1, 8'h1C, 1'b1);
        do_reset();

        // Make / break / make, then a single pop.
        send(8'h1C); send(8'hF0); send(8'h1C);
        pop_one();
        check("req034_data", 32'(rd_data), 32'h01C);
        check("req034_empty", 32'(empty), 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Extended make followed by extended break.
        do_reset();
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        check("req035_count", 32'(count), 32'd1);
        pop_one();
        check("req035_data", 32'(rd_data), 32'h175);

        // Overfill with 9 codes, then drain.
        do_reset();
        for (int i = 0; i < 9; i++) send(8'h10 + 8'(i));
        check("req036_full", 32'(full), 32'd1);
        check("req036_ovf", 32'(overflow), 32'd1);
        for (int i = 0; i < 8; i++) begin
            pop_one();
            check("req036_order", 32'(rd_data), 32'h010 + i);
        end
        check("req036_empty", 32'(empty), 32'd1);

        // Push and pop together while full.
        do_reset();
        for (int i = 0; i < 8; i++) send(8'h10 + 8'(i));
        step(1'b0, 1'b1, 8'h20, 1'b1);
        check("req037_count", 32'(count), 32'd8);
        check("req037_ovf", 32'(overflow), 32'd0);
        check("req037_data", 32'(rd_data), 32'h010);

        // Pop on empty, with and without a simultaneous push.
        do_reset();
        pop_one();
        check("req038_valid", 32'(rd_valid), 32'd0);
        step(1'b0, 1'b1, 8'h29, 1'b1);
        check("req038_count", 32'(count), 32'd1);

        // Reset discards a pending break prefix.
        do_reset();
        send(8'hF0);
        do_reset();
        send(8'h1C);
        pop_one();
        check("req039_data", 32'(rd_data), 32'h01C);

        // Randomized traffic with varying drain rates.
        do_reset();
        for (int phase = 0; phase < 4; phase++) begin
            int rd_pct;
            rd_pct = (phase == 0) ? 10 : (phase == 2) ? 75 : 40;
            for (int i = 0; i < 600; i++) begin
                step($urandom_range(0, 199) == 0,
                     $urandom_range(0, 99) < 60,
                     rand_byte(),
                     $urandom_range(0, 99) < rd_pct);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/scancode_fifo.md
SCANCODE_FIFO -- requirements
Module: scancode_fifo

Interface
REQ-001 Parameter: DEPTH, 8, number of FIFO entries; a power of two, at least 2.
REQ-002 Parameter: ADDR_W, 3, pointer width, equal to log2(DEPTH).
REQ-003 Port: clk  input  1  single system clock; every register updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: rx_data  input  8  received PS/2 byte, already synchronized to clk.
REQ-006 Port: rx_valid  input  1  one-cycle strobe; rx_data is valid in that cycle.
REQ-007 Port: rd_req  input  1  pop request from the memory controller.
REQ-008 Port: rd_data  output  9  popped entry, {ext, code}.
REQ-009 Port: rd_valid  output  1  one-cycle strobe; rd_data is valid in that cycle.
REQ-010 Port: empty  output  1  high when count is 0.
REQ-011 Port: full  output  1  high when count equals DEPTH.
REQ-012 Port: count  output  ADDR_W+1  number of stored entries, 0 to DEPTH.
REQ-013 Port: overflow  output  1  sticky flag: a make code was dropped because the FIFO was full.

Function
REQ-014 The decoder FSM shall have four states: NORM, EXT, BRK, EXTBRK. Transitions occur only in cycles where rx_valid=1.
REQ-015 NORM: 8'hE0 -> EXT; 8'hF0 -> BRK; 8'h00 or 8'hFF -> NORM with no push; any other byte -> push {1'b0, byte}, stay in NORM.
REQ-016 EXT: 8'hF0 -> EXTBRK; 8'hE0 -> EXT with no push; any other byte -> push {1'b1, byte}, go to NORM.
REQ-017 BRK and EXTBRK: any byte -> NORM with no push; break (release) codes are discarded.
REQ-018 A push writes mem[wr_ptr] and increments wr_ptr modulo DEPTH in the same cycle the byte is accepted.
REQ-019 A pop occurs when rd_req=1 and empty=0 at the clock edge. rd_data is loaded with mem[rd_ptr], rd_valid pulses high in the next cycle (latency 1), and rd_ptr increments modulo DEPTH.
REQ-020 rd_req while empty=1 shall be ignored: no pop, rd_valid stays 0, rd_data holds its value.
REQ-021 rd_data shall hold its last value until the next pop. rd_valid shall be high for exactly one cycle per pop.
REQ-022 Push and pop in the same cycle with 0<count<DEPTH: both occur and count is unchanged.
REQ-023 Push when full=1 and no pop: the entry is dropped, pointers and count are unchanged, and overflow is set to 1.
REQ-024 Push when full=1 with a pop in the same cycle: both occur, count stays DEPTH, overflow is unchanged.
REQ-025 Pop when empty=1 with a push in the same cycle: only the push occurs and count becomes 1.
REQ-026 empty, full and count shall be registered and consistent with each other in every cycle.
REQ-027 overflow shall stay high until reset.
REQ-028 The FSM shall advance on every rx_valid byte regardless of FIFO fullness.
REQ-029 Pointer wrap-around from DEPTH-1 to 0 shall not disturb ordering; entries are popped strictly in push order.

Reset
REQ-030 When reset=1 at a clock edge: state=NORM, wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, overflow=0, rd_valid=0, rd_data=9'h000.
REQ-031 Reset shall take priority over a simultaneous rx_valid or rd_req; those inputs are ignored in that cycle.
REQ-032 Reset mid-sequence (for example in state BRK) shall discard the partial sequence. The next byte is decoded from NORM.
REQ-033 Memory array contents need no reset. After reset they are unreachable until written.

Verification
REQ-034 Bytes 1C, F0, 1C, then pop -> one entry; rd_data=9'h01C with rd_valid high 1 cycle after rd_req; empty=1 afterwards.
REQ-035 Bytes E0, 75, E0, F0, 75 -> exactly one entry, 9'h175; count=1.
REQ-036 Push 9 distinct make codes with no pops -> full=1, count=8, overflow=1; popping 8 times returns the first 8 codes in order, then empty=1.
REQ-037 With count=8, push and rd_req in the same cycle -> count stays 8, overflow=0, oldest entry returned.
REQ-038 rd_req with the FIFO empty -> rd_valid=0 and rd_data unchanged. The same cycle with rx_valid and byte 29 -> count=1.
REQ-039 Bytes F0, then reset, then 1C -> one entry, 9'h01C, because reset discarded the pending break.
